moa_accum_seq: RTL and testbench

- Sequencer and accumulator around the existing 8-operand, 8-bit, two-stage multi-operand adder `moa_8x8p2_rt8_mfa42`.
- Accepts a programmable number of 8-operand groups over a valid/ready stream and feeds one group per cycle into the adder.
- Tracks in-flight groups through the adder's 2-cycle pipeline and accumulates each 11-bit group sum into a wide accumulator.
- Presents the final vector sum on a valid/ready result port; this is the block that turns the fixed-width adder into a long-vector reduction engine.

---
 rtl/moa_pkg.sv | 24 ++
 rtl/moa_accum_seq_if.sv | 26 ++
 rtl/moa_8x8p2_rt8_mfa42.sv | 45 ++++
 rtl/moa_accum_seq.sv | 164 ++++++++++++++++
 tb/tb_moa_accum_seq.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/moa_pkg.sv
// Shared types and constants for the multi-operand adder slice: the sequencer
// FSM states, the operand/sum geometry of the 8x8 adder and its pipeline depth.
package moa_pkg;

    localparam int MOA_OPS   = 8;   // operands per group
    localparam int MOA_OP_W  = 8;   // operand width
    localparam int MOA_SUM_W = 11;  // full-precision group sum width
    localparam int MOA_LAT   = 2;   // adder pipeline depth in cycles

    typedef logic [MOA_OP_W-1:0] moa_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } moa_state_e;

    // Full-precision sum of four operands (two bits of growth).
    function automatic logic [MOA_OP_W+1:0] add4(moa_op_t a, moa_op_t b, moa_op_t c, moa_op_t d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

endpackage

// File: rtl/moa_accum_seq_if.sv
// Operand stream and result port of the accumulating sequencer.
// master = producer/consumer side (testbench or upstream), slave = moa_accum_seq.
interface moa_accum_seq_if #(
    parameter int ACC_W = 24
);
    import moa_pkg::*;

    logic             in_valid;
    logic             in_ready;
    moa_op_t          x0, x1, x2, x3, x4, x5, x6, x7;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, x0, x1, x2, x3, x4, x5, x6, x7, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, x0, x1, x2, x3, x4, x5, x6, x7, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );

endinterface

// File: rtl/moa_8x8p2_rt8_mfa42.sv
// Two-stage 8-operand, 8-bit adder. Stage 1 reduces the operands to two
// 4-operand partial sums, stage 2 adds those into the 11-bit group sum.
// The sum for operands presented at edge k is visible after edge k+1.
module moa_8x8p2_rt8_mfa42
    import moa_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  moa_op_t              x0,
    input  moa_op_t              x1,
    input  moa_op_t              x2,
    input  moa_op_t              x3,
    input  moa_op_t              x4,
    input  moa_op_t              x5,
    input  moa_op_t              x6,
    input  moa_op_t              x7,
    output logic [MOA_SUM_W-1:0] sum
);

    logic [MOA_OP_W+1:0] part_lo_q;
    logic [MOA_OP_W+1:0] part_hi_q;

    // Stage 1: register the two partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is always written with <= so every register
            // samples the pre-edge values of its sources.
            part_lo_q <= '0;
            part_hi_q <= '0;
        end else begin
            part_lo_q <= add4(x0, x1, x2, x3);
            part_hi_q <= add4(x4, x5, x6, x7);
        end
    end

    // Stage 2: register the final group sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= {1'b0, part_lo_q} + {1'b0, part_hi_q};
        end
    end

endmodule

// File: rtl/moa_accum_seq.sv
// Long-vector reduction engine: accepts num_groups operand groups over a
// valid/ready stream, pushes one group per cycle through the two-stage adder,
// accumulates the group sums and presents the total on a valid/ready port.
// Build option: MOA_ACC_SAT_EN makes the accumulator saturate instead of wrap.
module moa_accum_seq
    import moa_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_groups,
    output logic             busy,
    moa_accum_seq_if.slave   bus
);

    moa_state_e           state_q;
    logic [CNT_W-1:0]     rem_q;
    logic [ACC_W-1:0]     acc_q;
    logic                 ovf_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 busy_q;
    logic [MOA_LAT-1:0]   vpipe_q;

    logic                 fire;
    moa_op_t              ops [MOA_OPS];
    logic [MOA_SUM_W-1:0] grp_sum;
    logic [ACC_W:0]       acc_ext;
    logic [ACC_W-1:0]     acc_next;
    logic                 acc_carry;
    logic                 drain_done;

    assign fire = bus.in_valid && in_ready_q;

    // Feed the adder only on a transfer so idle cycles contribute zero.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        for (int i = 0; i < MOA_OPS; i++) ops[i] = '0;
        if (fire) begin
            ops[0] = bus.x0;
            ops[1] = bus.x1;
            ops[2] = bus.x2;
            ops[3] = bus.x3;
            ops[4] = bus.x4;
            ops[5] = bus.x5;
            ops[6] = bus.x6;
            ops[7] = bus.x7;
        end
    end

    moa_8x8p2_rt8_mfa42 u_adder (
        .clk   (clk),
        .rst_n (rst_n),
        .x0    (ops[0]),
        .x1    (ops[1]),
        .x2    (ops[2]),
        .x3    (ops[3]),
        .x4    (ops[4]),
        .x5    (ops[5]),
        .x6    (ops[6]),
        .x7    (ops[7]),
        .sum   (grp_sum)
    );

    // Track which adder output cycles carry a real group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= {vpipe_q[MOA_LAT-2:0], fire};
        end
    end

    // The last group leaves the adder when the oldest slot is full and
    // nothing is behind it.
    assign drain_done = vpipe_q[MOA_LAT-1] && !(|vpipe_q[MOA_LAT-2:0]);

    // Next accumulator value: one extra bit captures the carry out.
    always_comb begin
        acc_ext   = {1'b0, acc_q} + (ACC_W+1)'(grp_sum);
        acc_carry = acc_ext[ACC_W];
`ifdef MOA_ACC_SAT_EN
        // Once clamped, any further non-zero addend carries again, so the
        // accumulator stays at full scale for the rest of the operation.
        acc_next  = acc_carry ? {ACC_W{1'b1}} : acc_ext[ACC_W-1:0];
`else
        acc_next  = acc_ext[ACC_W-1:0];
`endif
    end

    // Sequencer FSM with group counter, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // The pipe is empty in IDLE and DONE, so accumulating here never
            // collides with the clear on start.
            if (vpipe_q[MOA_LAT-1]) begin
                acc_q <= acc_next;
                if (acc_carry) ovf_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (num_groups == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q    <= ACCUM;
                            rem_q      <= num_groups;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (fire) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_moa_accum_seq.sv
// Self-checking bench for moa_accum_seq: a vector table of whole operations
// (expected results queued at launch, popped at the result handshake), plus
// hand-written overflow and mid-operation reset sequences.
module tb_moa_accum_seq;
    import moa_pkg::*;

    localparam int ACC_W   = 24;
    localparam int ACC_W_O = 12;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start, start_o;
    logic [CNT_W-1:0] num_groups, num_groups_o;
    logic             busy, busy_o;

    always #5 clk = ~clk;

    moa_accum_seq_if #(.ACC_W(ACC_W))   bus ();
    moa_accum_seq_if #(.ACC_W(ACC_W_O)) bus_o ();

    moa_accum_seq #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_groups (num_groups),
        .busy       (busy),
        .bus        (bus.slave)
    );

    moa_accum_seq #(.ACC_W(ACC_W_O), .CNT_W(CNT_W)) dut_o (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_o),
        .num_groups (num_groups_o),
        .busy       (busy_o),
        .bus        (bus_o.slave)
    );

    typedef struct {
        int               n;
        logic [7:0][7:0]  xs;     // xs[i] drives x<i>, same for every group
        int               gap;    // idle cycles between groups
        int               hold;   // cycles out_ready stays low in DONE
        logic [ACC_W-1:0] exp_sum;
        logic             exp_ovf;
    } vec_t;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_x(input logic [7:0][7:0] xs);
        bus.x0 = xs[0]; bus.x1 = xs[1]; bus.x2 = xs[2]; bus.x3 = xs[3];
        bus.x4 = xs[4]; bus.x5 = xs[5]; bus.x6 = xs[6]; bus.x7 = xs[7];
    endtask

    task automatic drive_x_o(input logic [7:0][7:0] xs);
        bus_o.x0 = xs[0]; bus_o.x1 = xs[1]; bus_o.x2 = xs[2]; bus_o.x3 = xs[3];
        bus_o.x4 = xs[4]; bus_o.x5 = xs[5]; bus_o.x6 = xs[6]; bus_o.x7 = xs[7];
    endtask

    // One complete operation on the 24-bit instance.
    task automatic run_vec(input vec_t v);
        int   lat;
        int   miss;
        logic stable;
        exp_t e;
        start      = 1'b1;
        num_groups = CNT_W'(v.n);
        sb.push_back('{sum: v.exp_sum, ovf: v.exp_ovf});
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (v.n == 0) begin
            check("zero_grp_done_next", bus.out_valid, 1);
            check("zero_grp_no_ready", bus.in_ready, 0);
        end else begin
            miss = 0;
            for (int g = 0; g < v.n; g++) begin
                drive_x(v.xs);
                bus.in_valid = 1'b1;
                if (!bus.in_ready) miss++;
                tick();
                if (g != v.n - 1 && v.gap > 0) begin
                    bus.in_valid = 1'b0;
                    // A start while busy must be ignored.
                    start      = 1'b1;
                    num_groups = 8'd200;
                    repeat (v.gap) tick();
                    start = 1'b0;
                end
            end
            bus.in_valid = 1'b0;
            drive_x('0);
            check("in_ready_every_group", miss, 0);
            check("in_ready_drop", bus.in_ready, 0);
            lat = 1;
            while (!bus.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("latency", lat, 3);
        end
        stable = 1'b1;
        for (int c = 0; c < v.hold; c++) begin
            tick();
            if (!bus.out_valid || bus.out_sum !== v.exp_sum) stable = 1'b0;
        end
        if (v.hold > 0) check("hold_stable", stable, 1);
        check("out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            e = sb.pop_front();
            check("out_sum", bus.out_sum, e.sum);
            check("out_ovf", bus.out_ovf, e.ovf);
        end
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
        check("idle_after_handshake", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC_W_O-1:0] exp_o;
        int                 lat;
        vec_t               v_rst;

        start = 1'b0; num_groups = '0; start_o = 1'b0; num_groups_o = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; drive_x('0);
        bus_o.in_valid = 1'b0; bus_o.out_ready = 1'b0; drive_x_o('0);

        vecs[0] = '{n: 1,   xs: {8{8'd255}}, gap: 0, hold: 0, exp_sum: 24'd2040,   exp_ovf: 1'b0};
        vecs[1] = '{n: 4,   xs: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    gap: 0, hold: 0, exp_sum: 24'd144, exp_ovf: 1'b0};
        vecs[2] = '{n: 3,   xs: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    gap: 2, hold: 5, exp_sum: 24'd108, exp_ovf: 1'b0};
        vecs[3] = '{n: 0,   xs: {8{8'd99}},  gap: 0, hold: 2, exp_sum: 24'd0,      exp_ovf: 1'b0};
        vecs[4] = '{n: 5,   xs: {8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10},
                    gap: 1, hold: 0, exp_sum: 24'd1800, exp_ovf: 1'b0};
        vecs[5] = '{n: 255, xs: {8{8'd255}}, gap: 0, hold: 0, exp_sum: 24'd520200, exp_ovf: 1'b0};

        // Reset state.
        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Overflow on the 12-bit instance: 3 groups of 2040 = 6120.
`ifdef MOA_ACC_SAT_EN
        exp_o = 12'd4095;
`else
        exp_o = 12'd2024;
`endif
        start_o = 1'b1;
        num_groups_o = 8'd3;
        tick();
        start_o = 1'b0;
        drive_x_o({8{8'd255}});
        bus_o.in_valid = 1'b1;
        repeat (3) tick();
        bus_o.in_valid = 1'b0;
        lat = 1;
        while (!bus_o.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("ovf_latency", lat, 3);
        check("ovf_out_sum", bus_o.out_sum, exp_o);
        check("ovf_flag", bus_o.out_ovf, 1);
        bus_o.out_ready = 1'b1;
        tick();
        bus_o.out_ready = 1'b0;
        check("ovf_idle", busy_o, 0);

        // Reset in the middle of ACCUM after 2 of 5 groups.
        start = 1'b1;
        num_groups = 8'd5;
        tick();
        start = 1'b0;
        drive_x({8{8'd255}});
        bus.in_valid = 1'b1;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst_partial_sum", bus.out_sum, 4080);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_sum", bus.out_sum, 0);
        check("midrst_out_ovf", bus.out_ovf, 0);
        check("midrst_busy", busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("postrst_no_result", bus.out_valid, 0);
        v_rst = '{n: 2, xs: {8{8'd1}}, gap: 0, hold: 0, exp_sum: 24'd16, exp_ovf: 1'b0};
        run_vec(v_rst);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
